// File: rtl/hazard_forward_unit.sv
// Forwarding selects and load-use/branch/freeze hazard control for the 5-stage MIPS pipeline.
// Optional performance counters are enabled with `define HAZARD_PERF_EN.
module hazard_forward_unit #(
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter int unsigned CNT_W        = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs_id,
  input  logic [REG_ADDR_W-1:0] rt_id,
  input  logic                  rt_used_id,
  input  logic [REG_ADDR_W-1:0] rsEX,
  input  logic [REG_ADDR_W-1:0] rtEX,
  input  logic                  memReadEX,
  input  logic                  regWriteMEM,
  input  logic [REG_ADDR_W-1:0] rd_writeRegMEM,
  input  logic                  regWriteWB,
  input  logic [REG_ADDR_W-1:0] rd_writeRegWB,
  input  logic                  branch_taken_id,
  input  logic                  ext_freeze,
  output logic [1:0]            data1mux_sel,
  output logic [1:0]            data2mux_sel,
  output logic                  stall_pc,
  output logic                  stall_ifid,
  output logic                  flush_idex,
  output logic                  flush_ifid,
  output logic                  freeze_all
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           freeze_cycles
`endif
);

  localparam int unsigned BUBBLE_INIT = (LOAD_BUBBLES > 1) ? LOAD_BUBBLES - 2 : 0;
  localparam logic [1:0]  SEL_RF  = 2'b00;
  localparam logic [1:0]  SEL_WB  = 2'b01;
  localparam logic [1:0]  SEL_MEM = 2'b10;

  typedef enum logic {IDLE, BUBBLE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hazard;

  // MEM result is younger than WB, so it takes priority; register 0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src);
    if (regWriteMEM && (rd_writeRegMEM != '0) && (rd_writeRegMEM == src)) return SEL_MEM;
    else if (regWriteWB && (rd_writeRegWB != '0) && (rd_writeRegWB == src)) return SEL_WB;
    else return SEL_RF;
  endfunction

  always_comb begin
    data1mux_sel = SEL_RF;
    data2mux_sel = SEL_RF;
    if (!rst) begin
      data1mux_sel = fwd_sel(rsEX);
      data2mux_sel = fwd_sel(rtEX);
    end
  end

  assign hazard = memReadEX && (rtEX != '0) &&
                  ((rtEX == rs_id) || (rt_used_id && (rtEX == rt_id)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Freeze overrides everything and holds the stall sequence in place.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_pc   = 1'b0;
    stall_ifid = 1'b0;
    flush_idex = 1'b0;
    freeze_all = 1'b0;
    if (rst) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (ext_freeze) begin
      freeze_all = 1'b1;
      stall_pc   = 1'b1;
      stall_ifid = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (hazard) begin
            stall_pc   = 1'b1;
            stall_ifid = 1'b1;
            flush_idex = 1'b1;
            if (LOAD_BUBBLES > 1) begin
              state_d = BUBBLE;
              cnt_d   = CNT_W'(BUBBLE_INIT);
            end
          end
        end
        BUBBLE: begin
          stall_pc   = 1'b1;
          stall_ifid = 1'b1;
          flush_idex = 1'b1;
          if (cnt_q == '0) state_d = IDLE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign flush_ifid = !rst && !ext_freeze && branch_taken_id && !stall_pc;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q, freeze_cycles_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q  <= '0;
      freeze_cycles_q <= '0;
    end else begin
      if (flush_idex && (stall_cycles_q != '1))  stall_cycles_q  <= stall_cycles_q + 32'd1;
      if (freeze_all && (freeze_cycles_q != '1)) freeze_cycles_q <= freeze_cycles_q + 32'd1;
    end
  end

  assign stall_cycles  = stall_cycles_q;
  assign freeze_cycles = freeze_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed self-checking bench for hazard_forward_unit built with LOAD_BUBBLES=3.
module tb_hazard_forward_unit;

  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rs_id, rt_id, rsEX, rtEX, rd_writeRegMEM, rd_writeRegWB;
  logic          rt_used_id, memReadEX, regWriteMEM, regWriteWB, branch_taken_id, ext_freeze;
  logic [1:0]    data1mux_sel, data2mux_sel;
  logic          stall_pc, stall_ifid, flush_idex, flush_ifid, freeze_all;
`ifdef HAZARD_PERF_EN
  logic [31:0]   stall_cycles, freeze_cycles;
`endif

  int n_vec = 0;
  int n_err = 0;

  hazard_forward_unit #(.REG_ADDR_W(AW), .LOAD_BUBBLES(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .rs_id(rs_id), .rt_id(rt_id), .rt_used_id(rt_used_id),
    .rsEX(rsEX), .rtEX(rtEX), .memReadEX(memReadEX),
    .regWriteMEM(regWriteMEM), .rd_writeRegMEM(rd_writeRegMEM),
    .regWriteWB(regWriteWB), .rd_writeRegWB(rd_writeRegWB),
    .branch_taken_id(branch_taken_id), .ext_freeze(ext_freeze),
    .data1mux_sel(data1mux_sel), .data2mux_sel(data2mux_sel),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .flush_idex(flush_idex),
    .flush_ifid(flush_ifid), .freeze_all(freeze_all)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(stall_cycles), .freeze_cycles(freeze_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are checked 1 time unit later.
  task automatic clear_inputs();
    rs_id = '0; rt_id = '0; rt_used_id = 1'b0; rsEX = '0; rtEX = '0; memReadEX = 1'b0;
    regWriteMEM = 1'b0; rd_writeRegMEM = '0; regWriteWB = 1'b0; rd_writeRegWB = '0;
    branch_taken_id = 1'b0; ext_freeze = 1'b0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] got;
    next_cycle();
    rst = 1'b1;
    rsEX = 5'd3; rtEX = 5'd3; regWriteMEM = 1'b1; rd_writeRegMEM = 5'd3;
    memReadEX = 1'b1; rs_id = 5'd3; branch_taken_id = 1'b1;
    #1;
    got = {data1mux_sel, data2mux_sel, stall_pc, stall_ifid, flush_idex, flush_ifid};
    n_vec++;
    if (got !== 8'h00) begin
      n_err++; $display("FAIL reset_outputs: got %h expected 00", got);
    end
    n_vec++;
    if (freeze_all !== 1'b0) begin
      n_err++; $display("FAIL reset_freeze: got %b expected 0", freeze_all);
    end
    next_cycle();
    clear_inputs();
    rst = 1'b0;
    #1;
    got = {data1mux_sel, data2mux_sel, stall_pc, stall_ifid, flush_idex, flush_ifid};
    n_vec++;
    if (got !== 8'h00) begin
      n_err++; $display("FAIL post_reset_idle: got %h expected 00", got);
    end
  endtask

  task automatic test_forward();
    next_cycle();
    rsEX = 5'd5; rd_writeRegMEM = 5'd5; rd_writeRegWB = 5'd5; regWriteMEM = 1'b1; regWriteWB = 1'b1;
    #1; n_vec++;
    if (data1mux_sel !== 2'b10) begin
      n_err++; $display("FAIL fwd_mem_priority: got %b expected 10", data1mux_sel);
    end
    regWriteMEM = 1'b0;
    #1; n_vec++;
    if (data1mux_sel !== 2'b01) begin
      n_err++; $display("FAIL fwd_wb: got %b expected 01", data1mux_sel);
    end
    regWriteWB = 1'b0;
    #1; n_vec++;
    if (data1mux_sel !== 2'b00) begin
      n_err++; $display("FAIL fwd_none: got %b expected 00", data1mux_sel);
    end
    clear_inputs();
    rtEX = 5'd0; rd_writeRegMEM = 5'd0; regWriteMEM = 1'b1; rd_writeRegWB = 5'd0; regWriteWB = 1'b1;
    #1; n_vec++;
    if (data2mux_sel !== 2'b00) begin
      n_err++; $display("FAIL fwd_reg0: got %b expected 00", data2mux_sel);
    end
    rtEX = 5'd9; rd_writeRegMEM = 5'd8; rd_writeRegWB = 5'd9; rsEX = 5'd8;
    #1; n_vec++;
    if ({data1mux_sel, data2mux_sel} !== 4'b1001) begin
      n_err++; $display("FAIL fwd_split: got %b expected 1001", {data1mux_sel, data2mux_sel});
    end
    rd_writeRegMEM = 5'd25;
    #1; n_vec++;
    if ({data1mux_sel, data2mux_sel} !== 4'b0001) begin
      n_err++; $display("FAIL fwd_full_width: got %b expected 0001", {data1mux_sel, data2mux_sel});
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    logic [2:0] exp_s [0:3];
    exp_s[0] = 3'b111; exp_s[1] = 3'b111; exp_s[2] = 3'b111; exp_s[3] = 3'b000;
    next_cycle();
    memReadEX = 1'b1; rtEX = 5'd7; rs_id = 5'd7;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin next_cycle(); memReadEX = 1'b0; end
      #1; n_vec++;
      if ({stall_pc, stall_ifid, flush_idex} !== exp_s[i]) begin
        n_err++;
        $display("FAIL load_use_cycle%0d: got %b expected %b", i, {stall_pc, stall_ifid, flush_idex}, exp_s[i]);
      end
    end
    next_cycle();
    memReadEX = 1'b1; rtEX = 5'd4; rs_id = 5'd1; rt_id = 5'd4; rt_used_id = 1'b0;
    #1; n_vec++;
    if (stall_pc !== 1'b0) begin
      n_err++; $display("FAIL rt_unused_no_hazard: got %b expected 0", stall_pc);
    end
    rtEX = 5'd0; rs_id = 5'd0;
    #1; n_vec++;
    if (stall_pc !== 1'b0) begin
      n_err++; $display("FAIL reg0_no_hazard: got %b expected 0", stall_pc);
    end
    clear_inputs();
  endtask

  task automatic test_freeze();
    // cycle: freeze input, expected {freeze_all, stall_pc, stall_ifid, flush_idex}
    logic       frz   [0:5];
    logic [3:0] exp_o [0:5];
    int         bubbles = 0;
    frz[0] = 0; frz[1] = 1; frz[2] = 1; frz[3] = 0; frz[4] = 0; frz[5] = 0;
    exp_o[0] = 4'b0111; exp_o[1] = 4'b1110; exp_o[2] = 4'b1110;
    exp_o[3] = 4'b0111; exp_o[4] = 4'b0111; exp_o[5] = 4'b0000;
    next_cycle();
    memReadEX = 1'b1; rtEX = 5'd7; rs_id = 5'd7; rsEX = 5'd2;
    regWriteWB = 1'b1; rd_writeRegWB = 5'd2;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin next_cycle(); memReadEX = 1'b0; end
      ext_freeze = frz[i];
      #1; n_vec++;
      if ({freeze_all, stall_pc, stall_ifid, flush_idex} !== exp_o[i]) begin
        n_err++;
        $display("FAIL freeze_cycle%0d: got %b expected %b", i,
                 {freeze_all, stall_pc, stall_ifid, flush_idex}, exp_o[i]);
      end
      if (flush_idex) bubbles++;
      if (i == 1) begin
        n_vec++;
        if (data1mux_sel !== 2'b01) begin
          n_err++; $display("FAIL freeze_forward: got %b expected 01", data1mux_sel);
        end
      end
    end
    n_vec++;
    if (bubbles != 3) begin
      n_err++; $display("FAIL freeze_total_bubbles: got %0d expected 3", bubbles);
    end
    clear_inputs();
  endtask

  task automatic test_branch();
    next_cycle();
    branch_taken_id = 1'b1;
    #1; n_vec++;
    if (flush_ifid !== 1'b1) begin
      n_err++; $display("FAIL branch_flush: got %b expected 1", flush_ifid);
    end
    memReadEX = 1'b1; rtEX = 5'd6; rt_id = 5'd6; rt_used_id = 1'b1;
    #1; n_vec++;
    if ({flush_ifid, stall_pc} !== 2'b01) begin
      n_err++; $display("FAIL branch_vs_stall: got %b expected 01", {flush_ifid, stall_pc});
    end
    next_cycle();
    memReadEX = 1'b0;
    #1; n_vec++;
    if ({flush_ifid, stall_pc} !== 2'b01) begin
      n_err++; $display("FAIL branch_in_bubble: got %b expected 01", {flush_ifid, stall_pc});
    end
    next_cycle();
    rst = 1'b1;
    #1; n_vec++;
    if ({stall_pc, stall_ifid, flush_idex, flush_ifid} !== 4'b0000) begin
      n_err++; $display("FAIL reset_mid_bubble: got %b expected 0000", {stall_pc, stall_ifid, flush_idex, flush_ifid});
    end
    next_cycle();
    rst = 1'b0; branch_taken_id = 1'b0;
    #1; n_vec++;
    if ({stall_pc, stall_ifid, flush_idex} !== 3'b000) begin
      n_err++; $display("FAIL idle_after_reset: got %b expected 000", {stall_pc, stall_ifid, flush_idex});
    end
    clear_inputs();
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int r = 0; r < 2; r++) begin
      next_cycle();
      memReadEX = 1'b1; rtEX = 5'd7; rs_id = 5'd7;
      next_cycle();
      memReadEX = 1'b0;
      next_cycle();
      next_cycle();
    end
    next_cycle();
    ext_freeze = 1'b1;
    next_cycle();
    ext_freeze = 1'b0;
    next_cycle();
    #1; n_vec++;
    if (stall_cycles !== 32'd6) begin
      n_err++; $display("FAIL perf_stall_cycles: got %0d expected 6", stall_cycles);
    end
    n_vec++;
    if (freeze_cycles !== 32'd1) begin
      n_err++; $display("FAIL perf_freeze_cycles: got %0d expected 1", freeze_cycles);
    end
    clear_inputs();
  endtask
`endif

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_forward();
    test_load_use();
    test_freeze();
    test_branch();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
